or_gate: RTL and testbench

Two-input bitwise OR primitive for the gate-level library. The combinational output `out` is the OR of `i1` and `i0`, valid within the same delta time as any input change. A registered copy of the result and a sticky "any-one-seen" flag are also provided, so downstream synchronous logic can use the OR result without adding its own flops.

---
 rtl/or_gate.sv | 23 ++
 tb/tb_or_gate.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/or_gate.sv
// or_gate: bitwise two-input OR with a registered copy and a sticky any-one-seen flag
module or_gate #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i0,
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] out_q,
    output logic             seen_one
);
    assign out = i1 | i0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_q    <= '0;
            seen_one <= 1'b0;
        end else begin
            if (en) out_q <= out;
            if (|out) seen_one <= 1'b1;
        end
endmodule

// File: tb/tb_or_gate.sv
// tb_or_gate: scoreboard bench for or_gate at WIDTH=1 and WIDTH=4
module tb_or_gate;
    logic clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic i1 = 1'b0, i0 = 1'b0;
    logic out, out_q, seen_one;
    logic [3:0] w1 = '0, w0 = '0;
    logic [3:0] wout, wout_q;
    logic wseen;
    logic [3:0] exp_q[$];
    logic [3:0] e;
    int tests = 0, fails = 0;

    or_gate #(.WIDTH(1)) u1 (.out(out), .i1(i1), .i0(i0), .clk(clk), .rst(rst), .en(en), .out_q(out_q), .seen_one(seen_one));
    or_gate #(.WIDTH(4)) u4 (.out(wout), .i1(w1), .i0(w0), .clk(clk), .rst(rst), .en(en), .out_q(wout_q), .seen_one(wseen));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++; if (out_q !== 1'b0) begin fails++; $display("FAIL reset_out_q got %b want 0", out_q); end
        tests++; if (seen_one !== 1'b0) begin fails++; $display("FAIL reset_seen got %b want 0", seen_one); end
        tests++; if (wout_q !== 4'b0) begin fails++; $display("FAIL reset_wout_q got %b want 0000", wout_q); end
        rst = 1'b0;
    endtask

    task automatic test_comb();
        for (int i = 0; i < 4; i++) begin
            {i1, i0} = 2'(i);
            exp_q.push_back({3'b0, i != 0});
            #1;
            e = exp_q.pop_front();
            tests++; if (out !== e[0]) begin fails++; $display("FAIL comb_%0d got %b want %b", i, out, e[0]); end
        end
    endtask

    task automatic test_reset_comb();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {i1, i0} = 2'(i);
            exp_q.push_back({3'b0, i != 0});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests++; if (out !== e[0]) begin fails++; $display("FAIL rst_comb_%0d got %b want %b", i, out, e[0]); end
            tests++; if (out_q !== 1'b0) begin fails++; $display("FAIL rst_hold_q_%0d got %b want 0", i, out_q); end
            tests++; if (seen_one !== 1'b0) begin fails++; $display("FAIL rst_hold_seen_%0d got %b want 0", i, seen_one); end
        end
        @(negedge clk);
        {i1, i0} = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_load();
        @(negedge clk);
        en = 1'b1;
        {i1, i0} = 2'b01;
        exp_q.push_back(4'd1);
        tick();
        e = exp_q.pop_front();
        tests++; if (out_q !== e[0]) begin fails++; $display("FAIL load1_q got %b want %b", out_q, e[0]); end
        tests++; if (seen_one !== 1'b1) begin fails++; $display("FAIL load1_seen got %b want 1", seen_one); end
        @(negedge clk);
        {i1, i0} = 2'b00;
        exp_q.push_back(4'd0);
        tick();
        e = exp_q.pop_front();
        tests++; if (out_q !== e[0]) begin fails++; $display("FAIL load0_q got %b want %b", out_q, e[0]); end
        tests++; if (seen_one !== 1'b1) begin fails++; $display("FAIL load0_sticky got %b want 1", seen_one); end
        tests++; if (wseen !== 1'b0) begin fails++; $display("FAIL wide_seen_idle got %b want 0", wseen); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b1;
        {i1, i0} = 2'b10;
        tick();
        @(negedge clk);
        en = 1'b0;
        {i1, i0} = 2'b00;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(4'd1);
            tick();
            e = exp_q.pop_front();
            tests++; if (out_q !== e[0]) begin fails++; $display("FAIL hold_q_%0d got %b want %b", c, out_q, e[0]); end
            tests++; if (out !== 1'b0) begin fails++; $display("FAIL hold_out_%0d got %b want 0", c, out); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        {i1, i0} = 2'b11;
        rst = 1'b1;
        #1;
        tests++; if (out_q !== 1'b0) begin fails++; $display("FAIL async_q got %b want 0", out_q); end
        tests++; if (seen_one !== 1'b0) begin fails++; $display("FAIL async_seen got %b want 0", seen_one); end
        tests++; if (out !== 1'b1) begin fails++; $display("FAIL async_out got %b want 1", out); end
        @(negedge clk);
        rst = 1'b0;
        {i1, i0} = 2'b00;
    endtask

    task automatic test_wide();
        @(negedge clk);
        w1 = 4'b1010;
        w0 = 4'b0110;
        exp_q.push_back(4'b1110);
        #1;
        tests++; if (wout !== exp_q[0]) begin fails++; $display("FAIL wide_out got %b want %b", wout, exp_q[0]); end
        en = 1'b1;
        tick();
        e = exp_q.pop_front();
        tests++; if (wout_q !== e) begin fails++; $display("FAIL wide_q got %b want %b", wout_q, e); end
        tests++; if (wseen !== 1'b1) begin fails++; $display("FAIL wide_seen got %b want 1", wseen); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b;
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
            w1 = a;
            w0 = b;
            exp_q.push_back(a | b);
            tick();
            e = exp_q.pop_front();
            tests++; if (wout_q !== e) begin fails++; $display("FAIL b2b_%0d got %b want %b", c, wout_q, e); end
        end
        en = 1'b0;
    endtask

    initial begin
        test_comb();
        test_reset();
        test_reset_comb();
        test_load();
        test_hold();
        test_async_reset();
        test_wide();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
